sccb_ov7670_responder: RTL and testbench

Behavioural SCCB/I2C responder modelling the OV7670 camera's register port. It is the sensor-side counterpart of the OV7670 configuration master. It decodes SCCB write and read transactions on oversampled SCL/SDA, drives ACK and read data open-drain, and holds a 256×8 register bank preloaded with the sensor ID values. It is used in simulation benches and loop-back FPGA builds so the camera init sequence can be checked without a physical sensor.

---
 rtl/sccb_ov7670_responder_pkg.sv | 42 ++++
 rtl/sccb_ov7670_responder_if.sv | 13 +
 rtl/sccb_line_sync.sv | 38 +++
 rtl/sccb_ov7670_responder.sv | 188 ++++++++++++++++++
 tb/tb_sccb_ov7670_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_ov7670_responder_pkg.sv
// Shared types and constants for the OV7670 SCCB responder: FSM states,
// default device address and the sensor ID register reset contents.
package sccb_resp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } state_e;

    localparam logic [6:0] OV_DEV_ADDR = 7'h21;

    localparam logic [7:0] PID_ADDR  = 8'h0A;
    localparam logic [7:0] PID_VAL   = 8'h76;
    localparam logic [7:0] VER_ADDR  = 8'h0B;
    localparam logic [7:0] VER_VAL   = 8'h73;
    localparam logic [7:0] MIDH_ADDR = 8'h1C;
    localparam logic [7:0] MIDH_VAL  = 8'h7F;
    localparam logic [7:0] MIDL_ADDR = 8'h1D;
    localparam logic [7:0] MIDL_VAL  = 8'hA2;
    localparam logic [7:0] COM7_ADDR = 8'h12;

    function automatic logic [7:0] reg_reset_val(input logic [7:0] addr);
        logic [7:0] val;
        case (addr)
            PID_ADDR:  val = PID_VAL;
            VER_ADDR:  val = VER_VAL;
            MIDH_ADDR: val = MIDH_VAL;
            MIDL_ADDR: val = MIDL_VAL;
            default:   val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/sccb_ov7670_responder_if.sv
// Pin-level SCCB bus plus the register-commit side channel of the responder.
interface sccb_ov7670_responder_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    modport master (output scl_i, sda_i, input sda_oe, wr_en, wr_addr, wr_data, busy);
    modport slave  (input scl_i, sda_i, output sda_oe, wr_en, wr_addr, wr_data, busy);
endinterface

// File: rtl/sccb_line_sync.sv
// Two-flop synchronisers for SCL/SDA followed by an edge register; all
// event outputs are registered, giving 3 clk from pin change to event.
module sccb_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_sda
);
    // [0],[1] form the synchroniser, [2] holds the previous synced level
    logic [2:0] r_scl;
    logic [2:0] r_sda;

    // Synchronise both lines and register the detected events
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl       <= 3'b111;
            r_sda       <= 3'b111;
            o_scl_rise  <= 1'b0;
            o_scl_fall  <= 1'b0;
            o_start_det <= 1'b0;
            o_stop_det  <= 1'b0;
            o_sda       <= 1'b1;
        end else begin
            r_scl       <= {r_scl[1:0], i_scl};
            r_sda       <= {r_sda[1:0], i_sda};
            o_scl_rise  <= r_scl[1] & ~r_scl[2];
            o_scl_fall  <= ~r_scl[1] & r_scl[2];
            o_start_det <= r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
            o_stop_det  <= r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];
            o_sda       <= r_sda[1];
        end
    end
endmodule

// File: rtl/sccb_ov7670_responder.sv
// OV7670-style SCCB register responder with a 256x8 bank. Defining
// SCCB_SOFT_RESET_EN makes a write of COM7 (0x12) bit 7 reload the bank.
module sccb_ov7670_responder
    import sccb_resp_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = OV_DEV_ADDR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sccb_ov7670_responder_if.slave        bus
);
    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

    sccb_line_sync u_sync (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_scl       (bus.scl_i),
        .i_sda       (bus.sda_i),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start),
        .o_stop_det  (w_stop),
        .o_sda       (w_sda)
    );

    state_e            r_state;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_ptr;
    logic              r_rw;
    logic              r_ack_seen;
    logic              r_sda_oe;
    logic              r_wr_en;
    logic [7:0]        r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic [255:0][7:0] r_bank;
`ifdef SCCB_SOFT_RESET_EN
    logic              r_soft_pend;
`endif

    logic [7:0] w_byte;
    logic [7:0] w_rd_byte;
    logic       w_rd_bit;
    logic       w_bit_done;
    logic       w_commit;

    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_rd_byte  = r_bank[r_ptr];
    assign w_rd_bit   = w_rd_byte[3'd7 - r_bitcnt];
    assign w_bit_done = (r_bitcnt == 3'd7);
    assign w_commit   = w_scl_rise && !w_stop && !w_start && (r_state == ST_WDATA) && w_bit_done;

    assign bus.sda_oe  = r_sda_oe;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = r_busy;

    // Register bank: reset/reload to sensor defaults, written on commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) r_bank[i] <= reg_reset_val(i[7:0]);
`ifdef SCCB_SOFT_RESET_EN
        end else if (r_soft_pend) begin
            for (int i = 0; i < 256; i++) r_bank[i] <= reg_reset_val(i[7:0]);
`endif
        end else if (w_commit) begin
            r_bank[r_ptr] <= w_byte;
        end
    end

    // Protocol FSM; bits sampled on SCL rise, SDA driven only on SCL fall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_ptr      <= 8'h00;
            r_rw       <= 1'b0;
            r_ack_seen <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 8'h00;
            r_busy     <= 1'b0;
`ifdef SCCB_SOFT_RESET_EN
            r_soft_pend <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
`ifdef SCCB_SOFT_RESET_EN
            r_soft_pend <= w_commit && (r_ptr == COM7_ADDR) && w_byte[7];
`endif
            if (w_stop) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= 3'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state  <= ST_DEV;
                r_bitcnt <= 3'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b1;
            end else if (w_scl_rise) begin
                case (r_state)
                    ST_DEV, ST_SUB, ST_WDATA: begin
                        r_shift <= w_byte;
                        if (w_bit_done) begin
                            r_bitcnt   <= 3'd0;
                            r_ack_seen <= 1'b0;
                            if (r_state == ST_DEV) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    r_state <= ST_DEV_ACK;
                                    r_rw    <= w_byte[0];
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end else if (r_state == ST_SUB) begin
                                r_ptr   <= w_byte;
                                r_state <= ST_SUB_ACK;
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_byte;
                                r_ptr     <= r_ptr + 8'd1;
                                r_state   <= ST_WDATA_ACK;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    ST_RDATA: begin
                        if (w_bit_done) begin
                            r_bitcnt   <= 3'd0;
                            r_ack_seen <= 1'b0;
                            r_state    <= ST_RDATA_ACK;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: r_ack_seen <= 1'b1;
                    ST_RDATA_ACK: begin
                        if (!w_sda) begin
                            r_ptr      <= r_ptr + 8'd1;
                            r_ack_seen <= 1'b1;
                        end else begin
                            r_state <= ST_IGNORE;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    // First fall after bit 8 starts the ACK, the next one ends it
                    ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                        if (!r_ack_seen) begin
                            r_sda_oe <= 1'b1;
                        end else if (r_state == ST_DEV_ACK && r_rw) begin
                            r_state  <= ST_RDATA;
                            r_bitcnt <= 3'd0;
                            r_sda_oe <= ~w_rd_byte[7];
                        end else if (r_state == ST_DEV_ACK) begin
                            r_state  <= ST_SUB;
                            r_bitcnt <= 3'd0;
                            r_sda_oe <= 1'b0;
                        end else begin
                            r_state  <= ST_WDATA;
                            r_bitcnt <= 3'd0;
                            r_sda_oe <= 1'b0;
                        end
                    end
                    ST_RDATA: r_sda_oe <= ~w_rd_bit;
                    ST_RDATA_ACK: begin
                        if (r_ack_seen) begin
                            r_state  <= ST_RDATA;
                            r_bitcnt <= 3'd0;
                            r_sda_oe <= ~w_rd_byte[7];
                        end else begin
                            r_sda_oe <= 1'b0;
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sccb_ov7670_responder.sv
// Scoreboard bench: stimulus tasks push expected ACKs, read bytes, commits
// and spot checks into queues; one monitor process pops and compares.
module tb_sccb_ov7670_responder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    always #5 clk = ~clk;

    sccb_ov7670_responder_if bus ();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    sccb_ov7670_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] exp_wr[$];
    logic        exp_ack[$];
    logic        act_ack[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  act_rd[$];
    string       chk_nm[$];
    logic [7:0]  chk_act[$];
    logic [7:0]  chk_exp[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          oe_cnt  = 0;

    // Monitor: the only process that compares and counts
    initial begin
        logic [15:0] ew;
        logic        ea, aa;
        logic [7:0]  er, ar, ce, ca;
        string       cn;
        forever begin
            @(negedge clk);
            if (bus.sda_oe) oe_cnt++;
            if (bus.wr_en) begin
                n_tests++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_commit: unexpected wr_en addr=%h data=%h", bus.wr_addr, bus.wr_data);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({bus.wr_addr, bus.wr_data} !== ew) begin
                        n_fail++;
                        $display("FAIL wr_commit: got %h/%h want %h/%h", bus.wr_addr, bus.wr_data, ew[15:8], ew[7:0]);
                    end
                end
            end
            while (act_ack.size() > 0) begin
                aa = act_ack.pop_front();
                ea = exp_ack.pop_front();
                n_tests++;
                if (aa !== ea) begin
                    n_fail++;
                    $display("FAIL ack_bit: got %b want %b", aa, ea);
                end
            end
            while (act_rd.size() > 0) begin
                ar = act_rd.pop_front();
                er = exp_rd.pop_front();
                n_tests++;
                if (ar !== er) begin
                    n_fail++;
                    $display("FAIL read_byte: got %h want %h", ar, er);
                end
            end
            while (chk_act.size() > 0) begin
                cn = chk_nm.pop_front();
                ca = chk_act.pop_front();
                ce = chk_exp.pop_front();
                n_tests++;
                if (ca !== ce) begin
                    n_fail++;
                    $display("FAIL %s: got %h want %h", cn, ca, ce);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        chk_nm.push_back(nm);
        chk_exp.push_back(exp);
        chk_act.push_back(act);
    endtask

    task automatic wbit(input logic b);
        tick(5); m_sda = b;
        tick(5); m_scl = 1'b1;
        tick(10); m_scl = 1'b0;
    endtask

    task automatic rbit(output logic b);
        tick(5); m_sda = 1'b1;
        tick(5); m_scl = 1'b1;
        tick(5); b = bus.sda_i;
        tick(5); m_scl = 1'b0;
    endtask

    task automatic start_c();
        tick(2); m_sda = 1'b1;
        tick(5); m_scl = 1'b1;
        tick(5); m_sda = 1'b0;
        tick(5); m_scl = 1'b0;
    endtask

    task automatic stop_c();
        tick(5); m_sda = 1'b0;
        tick(5); m_scl = 1'b1;
        tick(5); m_sda = 1'b1;
        tick(5);
    endtask

    task automatic send(input logic [7:0] b, input logic ea);
        logic a;
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        exp_ack.push_back(ea);
        rbit(a);
        act_ack.push_back(a);
    endtask

    task automatic recv(input logic [7:0] e, input logic nack);
        logic [7:0] v;
        logic       bt;
        v = 8'h00;
        exp_rd.push_back(e);
        for (int i = 0; i < 8; i++) begin
            rbit(bt);
            v = {v[6:0], bt};
        end
        act_rd.push_back(v);
        wbit(nack);
    endtask

    task automatic read_reg(input logic [7:0] a, input logic [7:0] e);
        start_c(); send(8'h42, 1'b0); send(a, 1'b0);
        start_c(); send(8'h43, 1'b0); recv(e, 1'b1);
        stop_c();
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        start_c(); send(8'h42, 1'b0); send(a, 1'b0);
        exp_wr.push_back({a, d});
        send(d, 1'b0);
        stop_c();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int oe0;
        tick(5);
        rst_n = 1'b1;
        tick(2);
        chk("rst_sda_oe", {7'd0, bus.sda_oe}, 8'h00);
        chk("rst_wr_en", {7'd0, bus.wr_en}, 8'h00);
        chk("rst_wr_addr", bus.wr_addr, 8'h00);
        chk("rst_wr_data", bus.wr_data, 8'h00);
        chk("rst_busy", {7'd0, bus.busy}, 8'h00);

        // ID registers, with busy probed mid-transaction
        start_c(); send(8'h42, 1'b0);
        chk("busy_mid", {7'd0, bus.busy}, 8'h01);
        send(8'h1C, 1'b0);
        start_c(); send(8'h43, 1'b0); recv(8'h7F, 1'b1);
        stop_c(); tick(2);
        chk("busy_after_stop", {7'd0, bus.busy}, 8'h00);
        read_reg(8'h1D, 8'hA2);

        write_reg(8'h40, 8'hD0);
        read_reg(8'h40, 8'hD0);

        // Wrong device address is ignored entirely
        oe0 = oe_cnt;
        start_c(); send(8'h60, 1'b1); send(8'h40, 1'b1); send(8'h11, 1'b1);
        chk("busy_ignore", {7'd0, bus.busy}, 8'h01);
        stop_c(); tick(2);
        chk("busy_ignore_stop", {7'd0, bus.busy}, 8'h00);
        chk("oe_in_ignore", 8'(oe_cnt - oe0), 8'h00);

        // Pointer wrap on a two-byte burst write, then burst read
        start_c(); send(8'h42, 1'b0); send(8'hFF, 1'b0);
        exp_wr.push_back(16'hFF11); send(8'h11, 1'b0);
        exp_wr.push_back(16'h0022); send(8'h22, 1'b0);
        stop_c();
        read_reg(8'hFF, 8'h11);
        read_reg(8'h00, 8'h22);
        start_c(); send(8'h42, 1'b0); send(8'h0A, 1'b0);
        start_c(); send(8'h43, 1'b0); recv(8'h76, 1'b0); recv(8'h73, 1'b1);
        stop_c();

        // Partial data byte aborted by STOP
        start_c(); send(8'h42, 1'b0); send(8'h50, 1'b0);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
        stop_c(); tick(2);
        chk("busy_partial", {7'd0, bus.busy}, 8'h00);
        read_reg(8'h50, 8'h00);

        write_reg(8'h12, 8'h80);
        chk("wr_addr_hold", bus.wr_addr, 8'h12);
        chk("wr_data_hold", bus.wr_data, 8'h80);
`ifdef SCCB_SOFT_RESET_EN
        read_reg(8'h40, 8'h00);
        read_reg(8'h1C, 8'h7F);
        read_reg(8'h12, 8'h00);
`else
        read_reg(8'h12, 8'h80);
        read_reg(8'h40, 8'hD0);
`endif

        // Reset during the device-address ACK
        write_reg(8'h30, 8'h55);
        start_c();
        for (int i = 7; i >= 0; i--) wbit(i == 6 || i == 1);
        tick(8);
        chk("ack_oe_driven", {7'd0, bus.sda_oe}, 8'h01);
        rst_n = 1'b0;
        tick(1);
        chk("rst_mid_oe", {7'd0, bus.sda_oe}, 8'h00);
        chk("rst_mid_busy", {7'd0, bus.busy}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        m_sda = 1'b0;
        tick(2); m_scl = 1'b1;
        tick(5); m_sda = 1'b1;
        tick(10);
        read_reg(8'h30, 8'h00);
        read_reg(8'h1C, 8'h7F);

        tick(5);
        chk("exp_wr_left", 8'(exp_wr.size()), 8'h00);
        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
